div_issue_ctrl: RTL
===================

Name: div_issue_ctrl

Overview:
- Initiator side of the unsigned division interface.
- Accepts RISC-V M-extension DIV/DIVU/REM/REMU requests and converts signed operands to magnitudes.
- Computes leading-zero counts and drives one start to the unsigned divider core, then collects its quotient/remainder.
- Applies sign correction and RISC-V divide-by-zero semantics, and presents the result on a valid/ack writeback handshake.

Parameters:
- DIV_WIDTH, 32, operand/result width; power of two, >= 8.
- ID_W, 3, width of the instruction tag carried from issue to writeback.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- issue_valid  in  1  request present.
- issue_ready  out  1  block can accept a request (high only in IDLE).
- issue_op  in  2  [1]=remainder select, [0]=unsigned; 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- issue_rs1  in  DIV_WIDTH  dividend.
- issue_rs2  in  DIV_WIDTH  divisor.
- issue_id  in  ID_W  tag.
- div_start  out  1  one-cycle start pulse to the divider core.
- div_dividend  out  DIV_WIDTH  magnitude of dividend, registered.
- div_divisor  out  DIV_WIDTH  magnitude of divisor, registered.
- div_dividend_clz  out  $clog2(DIV_WIDTH)  leading zeros of div_dividend.
- div_divisor_clz  out  $clog2(DIV_WIDTH)  leading zeros of div_divisor.
- div_done  in  1  core completion.
- div_quotient  in  DIV_WIDTH  core quotient.
- div_remainder  in  DIV_WIDTH  core remainder.
- wb_valid  out  1  result available.
- wb_ack  in  1  result consumed.
- wb_data  out  DIV_WIDTH  result.
- wb_id  out  ID_W  tag of result.

Behaviour:
- Reset values:
  - State IDLE; issue_ready=1; div_start=0; wb_valid=0.
  - wb_data, wb_id, div_* data outputs = 0.
- Reset mid-operation: state returns to IDLE and the in-flight op is discarded. div_start must be low during and after reset.
- IDLE:
  - Issue handshake is issue_valid & issue_ready.
  - On handshake, latch: op, id, rs1 original, rs1 sign, rs2 sign, divisor-zero flag.
  - Also latch the magnitudes: |rs1| and |rs2| when signed and the operand MSB is set, else the raw values. |-2^(W-1)| = 2^(W-1) as an unsigned value.
  - Next state PREP.
- PREP (one cycle):
  - Register div_dividend_clz and div_divisor_clz from the latched magnitudes.
  - CLZ of zero saturates to DIV_WIDTH-1.
  - If divisor-zero: load the special result and go to RESULT (core never started). Else go to START.
- START (one cycle):
  - div_start=1.
  - div_dividend, div_divisor and both CLZ outputs are stable from PREP until return to IDLE.
  - If div_done is high in the same cycle (early termination, divisor > dividend): raw quotient = 0, raw remainder = latched dividend magnitude; go to RESULT. Core outputs are not sampled in this case.
  - Else go to WAIT.
- WAIT: hold until div_done, then go to CAPTURE.
- CAPTURE (one cycle): core registers hold their final values this cycle. Sample div_quotient/div_remainder, apply sign fix, load wb_data, go to RESULT.
- Sign fix (signed ops only; unsigned ops pass through):
  - Quotient is negated (two's complement) when the rs1 and rs2 signs differ.
  - Remainder is negated when rs1 is negative.
  - Overflow case -2^(W-1) / -1 falls out naturally: quotient 0x80..0, remainder 0.
- Divide-by-zero (any signedness): quotient = all ones; remainder = rs1 original value.
- RESULT:
  - wb_valid=1; wb_data = quotient if op[1]=0, else remainder; wb_id = latched id.
  - wb_data and wb_id are held stable while wb_valid & ~wb_ack.
  - On wb_ack, go to IDLE. The next issue is accepted no earlier than the cycle after ack.
- Latency, with the handshake in cycle T:
  - Divide-by-zero: wb_valid in T+2.
  - Early termination: wb_valid in T+3.
  - Otherwise: wb_valid 2 cycles after the div_done cycle.
- div_start is never asserted outside START. Exactly one start is issued per non-zero-divisor op.
- The core's done/result outputs are ignored in all states except START, WAIT and CAPTURE.

Test Plan:
- DIVU rs1=100, rs2=7 -> one div_start, dividend_clz=25, divisor_clz=29; wb_data=14. Repeat as REMU -> 2.
- REM rs1=-7 (0xFFFFFFF9), rs2=2 -> div_dividend=7; wb_data=0xFFFFFFFF (-1). DIV same operands -> 0xFFFFFFFD (-3).
- DIV rs1=0x80000000, rs2=0xFFFFFFFF -> wb_data=0x80000000; REM same operands -> 0.
- DIVU rs1=0x1234, rs2=0 -> no div_start, wb_valid at T+2, wb_data=0xFFFFFFFF; REM signed rs1=-5, rs2=0 -> 0xFFFFFFFB.
- REMU rs1=5, rs2=9 with the core asserting done in the start cycle -> wb_valid at T+3, wb_data=5; DIVU -> 0.
- Hold wb_ack low 4 cycles -> wb_valid, wb_data, wb_id stable and issue_ready=0. Assert rst during WAIT -> IDLE next cycle, issue_ready=1, wb_valid=0, no further div_start.

Source files
------------

// File: rtl/div_issue_ctrl_if.sv
// div_issue_ctrl_if
//   Bundles the three handshakes around the division issue controller:
//     issue_*  : request from the pipeline (valid/ready, op, operands, tag)
//     div_*    : start/done exchange with the unsigned divider core
//     wb_*     : result towards writeback (valid/ack, data, tag)
//   Modports:
//     master : the controller (initiator of the divider transaction)
//     slave  : the environment (issuing pipeline, divider core, writeback)
interface div_issue_ctrl_if #(
    parameter int DIV_WIDTH = 32,
    parameter int ID_W      = 3
);
    localparam int CLZ_W = $clog2(DIV_WIDTH);

    logic                 issue_valid;
    logic                 issue_ready;
    logic [1:0]           issue_op;
    logic [DIV_WIDTH-1:0] issue_rs1;
    logic [DIV_WIDTH-1:0] issue_rs2;
    logic [ID_W-1:0]      issue_id;

    logic                 div_start;
    logic [DIV_WIDTH-1:0] div_dividend;
    logic [DIV_WIDTH-1:0] div_divisor;
    logic [CLZ_W-1:0]     div_dividend_clz;
    logic [CLZ_W-1:0]     div_divisor_clz;
    logic                 div_done;
    logic [DIV_WIDTH-1:0] div_quotient;
    logic [DIV_WIDTH-1:0] div_remainder;

    logic                 wb_valid;
    logic                 wb_ack;
    logic [DIV_WIDTH-1:0] wb_data;
    logic [ID_W-1:0]      wb_id;

    modport master (
        input  issue_valid, issue_op, issue_rs1, issue_rs2, issue_id,
        output issue_ready,
        output div_start, div_dividend, div_divisor, div_dividend_clz, div_divisor_clz,
        input  div_done, div_quotient, div_remainder,
        output wb_valid, wb_data, wb_id,
        input  wb_ack
    );

    modport slave (
        output issue_valid, issue_op, issue_rs1, issue_rs2, issue_id,
        input  issue_ready,
        input  div_start, div_dividend, div_divisor, div_dividend_clz, div_divisor_clz,
        output div_done, div_quotient, div_remainder,
        input  wb_valid, wb_data, wb_id,
        output wb_ack
    );
endinterface

// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl
//   Issue-side controller for RISC-V DIV/DIVU/REM/REMU on top of an unsigned
//   divider core. Takes a request, converts signed operands to magnitudes,
//   computes leading-zero counts, fires one start to the core, collects the
//   quotient/remainder, applies sign correction and divide-by-zero results,
//   and offers the result on a valid/ack writeback handshake.
//   Ports:
//     clk, rst : clock, synchronous active-high reset
//     bus      : div_issue_ctrl_if.master (issue_*, div_*, wb_* signals)
module div_issue_ctrl #(
    parameter int DIV_WIDTH = 32,
    parameter int ID_W      = 3
) (
    input  logic             clk,
    input  logic             rst,
    div_issue_ctrl_if.master bus
);
    localparam int CLZ_W = $clog2(DIV_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE, S_PREP, S_START, S_WAIT, S_CAPTURE, S_RESULT
    } state_t;

    state_t               state;
    logic                 issue_ready_q;
    logic                 div_start_q;
    logic                 wb_valid_q;
    logic [DIV_WIDTH-1:0] wb_data_q;
    logic [ID_W-1:0]      wb_id_q;
    logic [DIV_WIDTH-1:0] dvd_mag_q;
    logic [DIV_WIDTH-1:0] dvs_mag_q;
    logic [CLZ_W-1:0]     dvd_clz_q;
    logic [CLZ_W-1:0]     dvs_clz_q;
    logic [DIV_WIDTH-1:0] rs1_q;
    logic [ID_W-1:0]      id_q;
    logic                 rem_sel_q;
    logic                 rs1_neg_q;
    logic                 rs2_neg_q;
    logic                 dvs_zero_q;

    logic                 issue_fire;
    logic                 issue_signed;
    logic [DIV_WIDTH-1:0] raw_quo;
    logic [DIV_WIDTH-1:0] raw_rem;
    logic [DIV_WIDTH-1:0] res_fixed;

    // Two's complement negation; the most negative value maps onto itself,
    // which read as unsigned is exactly its magnitude 2^(W-1).
    function automatic logic [DIV_WIDTH-1:0] negate(input logic [DIV_WIDTH-1:0] v);
        logic signed [DIV_WIDTH-1:0] s;
        s = $signed(v);
        return $unsigned(-s);
    endfunction

    function automatic logic [DIV_WIDTH-1:0] magnitude(input logic [DIV_WIDTH-1:0] v,
                                                       input logic               sgn);
        return (sgn && v[DIV_WIDTH-1]) ? negate(v) : v;
    endfunction

    // Leading-zero count; zero input saturates to DIV_WIDTH-1 so the result
    // always fits in CLZ_W bits.
    function automatic logic [CLZ_W-1:0] clz(input logic [DIV_WIDTH-1:0] v);
        logic [CLZ_W-1:0] n;
        logic             found;
        n     = CLZ_W'(DIV_WIDTH - 1);
        found = 1'b0;
        for (int i = DIV_WIDTH - 1; i >= 0; i--) begin
            if (!found && v[i]) begin
                n     = CLZ_W'(DIV_WIDTH - 1 - i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

    // Quotient sign follows sign(rs1) ^ sign(rs2); remainder follows rs1.
    // Neg flags are only ever set for signed ops, so unsigned passes through.
    function automatic logic [DIV_WIDTH-1:0] sign_fix(input logic               rem_sel,
                                                      input logic               n1,
                                                      input logic               n2,
                                                      input logic [DIV_WIDTH-1:0] q,
                                                      input logic [DIV_WIDTH-1:0] r);
        logic [DIV_WIDTH-1:0] qf;
        logic [DIV_WIDTH-1:0] rf;
        qf = (n1 ^ n2) ? negate(q) : q;
        rf = n1 ? negate(r) : r;
        return rem_sel ? rf : qf;
    endfunction

    assign issue_fire   = bus.issue_valid && issue_ready_q;
    assign issue_signed = ~bus.issue_op[0];

    // Early termination in START means divisor > dividend: the core's
    // outputs are not meaningful yet, so the raw result is synthesised here.
    always_comb begin
        raw_quo = bus.div_quotient;
        raw_rem = bus.div_remainder;
        if (state == S_START) begin
            raw_quo = '0;
            raw_rem = dvd_mag_q;
        end
        res_fixed = sign_fix(rem_sel_q, rs1_neg_q, rs2_neg_q, raw_quo, raw_rem);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            issue_ready_q <= 1'b1;
            div_start_q   <= 1'b0;
            wb_valid_q    <= 1'b0;
            wb_data_q     <= '0;
            wb_id_q       <= '0;
            dvd_mag_q     <= '0;
            dvs_mag_q     <= '0;
            dvd_clz_q     <= '0;
            dvs_clz_q     <= '0;
            rs1_q         <= '0;
            id_q          <= '0;
            rem_sel_q     <= 1'b0;
            rs1_neg_q     <= 1'b0;
            rs2_neg_q     <= 1'b0;
            dvs_zero_q    <= 1'b0;
        end else begin
            div_start_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (issue_fire) begin
                        rem_sel_q     <= bus.issue_op[1];
                        id_q          <= bus.issue_id;
                        rs1_q         <= bus.issue_rs1;
                        rs1_neg_q     <= issue_signed && bus.issue_rs1[DIV_WIDTH-1];
                        rs2_neg_q     <= issue_signed && bus.issue_rs2[DIV_WIDTH-1];
                        dvs_zero_q    <= (bus.issue_rs2 == '0);
                        dvd_mag_q     <= magnitude(bus.issue_rs1, issue_signed);
                        dvs_mag_q     <= magnitude(bus.issue_rs2, issue_signed);
                        issue_ready_q <= 1'b0;
                        state         <= S_PREP;
                    end
                end
                S_PREP: begin
                    dvd_clz_q <= clz(dvd_mag_q);
                    dvs_clz_q <= clz(dvs_mag_q);
                    if (dvs_zero_q) begin
                        // x/0: quotient all ones, remainder is the original rs1
                        wb_data_q  <= rem_sel_q ? rs1_q : '1;
                        wb_id_q    <= id_q;
                        wb_valid_q <= 1'b1;
                        state      <= S_RESULT;
                    end else begin
                        div_start_q <= 1'b1;
                        state       <= S_START;
                    end
                end
                S_START: begin
                    if (bus.div_done) begin
                        wb_data_q  <= res_fixed;
                        wb_id_q    <= id_q;
                        wb_valid_q <= 1'b1;
                        state      <= S_RESULT;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.div_done) state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    wb_data_q  <= res_fixed;
                    wb_id_q    <= id_q;
                    wb_valid_q <= 1'b1;
                    state      <= S_RESULT;
                end
                S_RESULT: begin
                    if (bus.wb_ack) begin
                        wb_valid_q    <= 1'b0;
                        issue_ready_q <= 1'b1;
                        state         <= S_IDLE;
                    end
                end
                default: begin
                    state         <= S_IDLE;
                    issue_ready_q <= 1'b1;
                    wb_valid_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.issue_ready      = issue_ready_q;
    assign bus.div_start        = div_start_q;
    assign bus.div_dividend     = dvd_mag_q;
    assign bus.div_divisor      = dvs_mag_q;
    assign bus.div_dividend_clz = dvd_clz_q;
    assign bus.div_divisor_clz  = dvs_clz_q;
    assign bus.wb_valid         = wb_valid_q;
    assign bus.wb_data          = wb_data_q;
    assign bus.wb_id            = wb_id_q;
endmodule
